instr_fetch: RTL

Instruction fetch stage. Holds the program counter, issues in-order word requests to instruction memory, buffers returned words in a small FIFO and presents them with their PC to the decode stage. The decode stage routes `instr_word` to the immediate generator and register-file read logic. Control-flow redirects from execute flush the buffer and discard responses still in flight.

---
 rtl/instr_fetch_if.sv | 43 ++++
 rtl/instr_fetch.sv | 120 ++++++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: instruction memory request/response,
// redirect from execute, and the instruction handoff to decode.
interface instr_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_word;
  logic [31:0] instr_pc;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    output instr_word,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    input  instr_word,
    input  instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, in-order memory requests, pc-tag FIFO
// and an instruction FIFO feeding decode, flushed on redirect.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input logic           clk,
  input logic           rst_n,
  instr_fetch_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [31:0]   pc;
  logic [31:0]   q_word [DEPTH];
  logic [31:0]   q_pc   [DEPTH];
  logic [31:0]   tag    [DEPTH];
  logic [PW-1:0] q_rd;
  logic [PW-1:0] q_wr;
  logic [PW-1:0] t_rd;
  logic [PW-1:0] t_wr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;

  logic [CW:0] credit;
  logic        accept;
  logic        keep;
  logic        pop;
  logic        unused_bits;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign credit = {1'b0, outstanding}
                + {1'b0, count};

  assign bus.imem_req_valid = !bus.redirect_valid
                           && (credit < (CW+1)'(DEPTH))
                           && rst_n;
  assign bus.imem_addr = pc;

  assign accept = bus.imem_req_valid
               && bus.imem_req_ready;
  assign keep   = bus.imem_rsp_valid
               && (drop == '0);
  assign pop    = bus.instr_valid
               && bus.instr_ready;

  assign bus.instr_valid = (count != '0);
  assign bus.instr_word  = bus.instr_valid
                         ? q_word[q_rd] : '0;
  assign bus.instr_pc    = bus.instr_valid
                         ? q_pc[q_rd] : '0;

  assign unused_bits = ^bus.redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      q_rd        <= '0;
      q_wr        <= '0;
      t_rd        <= '0;
      t_wr        <= '0;
    end else if (bus.redirect_valid) begin
      // the response landing this cycle is stale and not counted as a drop
      pc          <= {bus.redirect_pc[31:2], 2'b00};
      count       <= '0;
      q_rd        <= '0;
      q_wr        <= '0;
      t_rd        <= '0;
      t_wr        <= '0;
      drop        <= outstanding
                   - CW'(bus.imem_rsp_valid);
      outstanding <= outstanding
                   - CW'(bus.imem_rsp_valid);
    end else begin
      if (bus.imem_rsp_valid)
        assert (outstanding != '0);
      if (keep)
        assert (count != CW'(DEPTH) || pop);

      if (accept) begin
        pc        <= pc + 32'd4;
        tag[t_wr] <= pc;
        t_wr      <= inc(t_wr);
      end

      outstanding <= outstanding
                   + CW'(accept)
                   - CW'(bus.imem_rsp_valid);

      // stale tags were flushed, so drops leave the tag FIFO alone
      if (bus.imem_rsp_valid && drop != '0)
        drop <= drop - 1'b1;

      if (keep) begin
        q_word[q_wr] <= bus.imem_rsp_data;
        q_pc[q_wr]   <= tag[t_rd];
        q_wr         <= inc(q_wr);
        t_rd         <= inc(t_rd);
      end

      if (pop)
        q_rd <= inc(q_rd);

      count <= count
             + CW'(keep)
             - CW'(pop);
    end
  end

endmodule
